// File: rtl/cond_flag_unit.sv
// Conditional-execution stage: NZCV flag register, ARM condition evaluation and write-strobe gating.
// Optional saturating exec/skip counters are built when COND_PERF_CNT_EN is defined.
module cond_flag_unit #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [3:0]       cond,
  input  logic [3:0]       alu_flags,
  input  logic [1:0]       flag_w,
  input  logic             pcs,
  input  logic             reg_w,
  input  logic             mem_w,
  input  logic             no_write,
  output logic             pc_src,
  output logic             reg_write,
  output logic             mem_write,
  output logic             cond_ex,
  output logic [3:0]       flags,
  output logic [CNT_W-1:0] exec_cnt,
  output logic [CNT_W-1:0] skip_cnt
);

  typedef enum logic [3:0] {
    C_EQ = 4'h0, C_NE = 4'h1, C_CS = 4'h2, C_CC = 4'h3,
    C_MI = 4'h4, C_PL = 4'h5, C_VS = 4'h6, C_VC = 4'h7,
    C_HI = 4'h8, C_LS = 4'h9, C_GE = 4'hA, C_LT = 4'hB,
    C_GT = 4'hC, C_LE = 4'hD, C_AL = 4'hE, C_NV = 4'hF
  } cond_e;

  logic [3:0] flags_q, flags_d;
  logic       n, z, c, v;
  logic       cond_pass;
  cond_e      cond_c;

  assign {n, z, c, v} = flags_q;
  assign cond_c       = cond_e'(cond);

  always_comb begin
    cond_pass = 1'b0;
    case (cond_c)
      C_EQ: cond_pass = z;
      C_NE: cond_pass = ~z;
      C_CS: cond_pass = c;
      C_CC: cond_pass = ~c;
      C_MI: cond_pass = n;
      C_PL: cond_pass = ~n;
      C_VS: cond_pass = v;
      C_VC: cond_pass = ~v;
      C_HI: cond_pass = c & ~z;
      C_LS: cond_pass = ~c | z;
      C_GE: cond_pass = (n == v);
      C_LT: cond_pass = (n != v);
      C_GT: cond_pass = ~z & (n == v);
      C_LE: cond_pass = z | (n != v);
      C_AL: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  // Reset gates the strobes combinationally so nothing escapes during reset.
  assign cond_ex   = reset & en & cond_pass;
  assign pc_src    = pcs & cond_ex;
  assign reg_write = reg_w & ~no_write & cond_ex;
  assign mem_write = mem_w & cond_ex;
  assign flags     = flags_q;

  always_comb begin
    flags_d = flags_q;
    if (cond_ex) begin
      if (flag_w[1]) flags_d[3:2] = alu_flags[3:2];
      if (flag_w[0]) flags_d[1:0] = alu_flags[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) flags_q <= '0;
    else        flags_q <= flags_d;
  end

`ifdef COND_PERF_CNT_EN
  logic [CNT_W-1:0] exec_q, exec_d, skip_q, skip_d;

  always_comb begin
    exec_d = exec_q;
    skip_d = skip_q;
    if (cond_ex) begin
      if (exec_q != '1) exec_d = exec_q + CNT_W'(1);
    end else if (en) begin
      if (skip_q != '1) skip_d = skip_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      exec_q <= '0;
      skip_q <= '0;
    end else begin
      exec_q <= exec_d;
      skip_q <= skip_d;
    end
  end

  assign exec_cnt = exec_q;
  assign skip_cnt = skip_q;
`else
  assign exec_cnt = '0;
  assign skip_cnt = '0;
`endif

endmodule
